// File: rtl/tipi_pkg.sv
// Shared constants and types for the TIPI PEB byte/nibble datapath.
package tipi_pkg;

  localparam int TIPI_BYTE_W = 8;
  localparam int TIPI_NIB_W  = 4;

  typedef logic [TIPI_NIB_W-1:0] nib_t;

endpackage

// File: rtl/shift_pload_nibble_out.sv
// Parallel-load shift register that presents a captured byte one nibble at a
// time, most-significant nibble first, back-filling zeros as it shifts.
module shift_pload_nibble_out
  import tipi_pkg::*;
#(
  parameter int DATA_W = TIPI_BYTE_W,
  parameter int NIB_W  = TIPI_NIB_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              select,
  input  logic              le,
  input  logic [DATA_W-1:0] data,
  output logic [NIB_W-1:0]  nout
);

  // The register must split into a whole number of nibbles.
  generate
    if (NIB_W <= 0 || DATA_W <= 0 || (DATA_W % NIB_W) != 0) begin : g_bad_width
      $error("shift_pload_nibble_out: DATA_W must be a non-zero multiple of NIB_W");
    end
  endgenerate

  logic [DATA_W-1:0] sreg;

  // Reset beats load, load beats shift; a deselected block holds its contents.
  // The shift is written as a constant left shift so a single-nibble register
  // simply empties to zero instead of needing an empty slice.
  always_ff @(posedge clk) begin
    if (reset) begin
      sreg <= '0;
    end else if (select) begin
      if (le) begin
        sreg <= data;
      end else begin
        sreg <= sreg << NIB_W;
      end
    end
  end

  // The top nibble is always the one on the wire; no extra output register.
  assign nout = sreg[DATA_W-1 -: NIB_W];

endmodule

// File: tb/tb_shift_pload_nibble_out.sv
// Directed bench for shift_pload_nibble_out with a queue-based scoreboard.
module tb_shift_pload_nibble_out;

  logic       clk;
  logic       reset;
  logic       select;
  logic       le;
  logic [7:0] data;
  logic [3:0] nout;

  typedef struct {
    logic [3:0] exp;
    string      name;
  } exp_t;

  exp_t q[$];
  int   n_tests;
  int   n_fail;

  shift_pload_nibble_out #(
    .DATA_W(8),
    .NIB_W (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .select(select),
    .le    (le),
    .data  (data),
    .nout  (nout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic compare(input logic [3:0] got, input logic [3:0] exp, input string nm);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: nout=%h expected=%h", nm, got, exp);
    end
  endtask

  // Drive one cycle's inputs on the falling edge; queue the nout expected
  // just after the following rising edge.
  task automatic step(input logic r, input logic s, input logic l,
                      input logic [7:0] d, input bit chk,
                      input logic [3:0] e, input string nm);
    exp_t item;
    @(negedge clk);
    reset  = r;
    select = s;
    le     = l;
    data   = d;
    if (chk) begin
      item.exp  = e;
      item.name = nm;
      q.push_back(item);
    end
  endtask

  // Monitor: one expectation is consumed per rising edge, sampled 1 time unit later.
  initial begin
    exp_t item;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        item = q.pop_front();
        compare(nout, item.exp, item.name);
      end
    end
  end

  initial begin
    int guard;
    n_tests = 0;
    n_fail  = 0;
    reset   = 1'b0;
    select  = 1'b0;
    le      = 1'b0;
    data    = 8'h00;

    // reset must win over a simultaneous load of FF
    step(1, 1, 1, 8'hFF, 1, 4'h0, "reset_wins_over_load");
    step(0, 1, 1, 8'h00, 1, 4'h0, "load_00");

    // change le/data between edges: nothing may leak through
    @(negedge clk);
    le   = 1'b0;
    data = 8'hAF;
    #2;
    compare(nout, 4'h0, "no_premature_load");

    // load AF and drain it, then keep shifting past exhaustion
    step(0, 1, 1, 8'hAF, 1, 4'hA, "load_AF_hi");
    step(0, 1, 0, 8'h00, 1, 4'hF, "shift_AF_lo");
    step(0, 1, 0, 8'h00, 1, 4'h0, "shift_AF_empty");
    step(0, 1, 0, 8'h00, 1, 4'h0, "shift_AF_stay0_a");
    step(0, 1, 0, 8'h00, 1, 4'h0, "shift_AF_stay0_b");

    // deselected block ignores edges, le and data
    step(0, 1, 1, 8'h5C, 1, 4'h5, "load_5C");
    step(0, 0, 1, 8'hFF, 1, 4'h5, "hold_sel0_a");
    step(0, 0, 0, 8'h00, 1, 4'h5, "hold_sel0_b");
    step(0, 0, 1, 8'h93, 1, 4'h5, "hold_sel0_c");
    step(0, 1, 0, 8'h00, 1, 4'hC, "shift_5C_lo");
    step(0, 1, 0, 8'h00, 1, 4'h0, "shift_5C_empty");

    // reload mid-stream restarts at the new high nibble
    step(0, 1, 1, 8'h5C, 1, 4'h5, "load_5C_again");
    step(0, 1, 1, 8'h93, 1, 4'h9, "reload_93_hi");
    step(0, 1, 0, 8'h00, 1, 4'h3, "shift_93_lo");
    step(0, 1, 0, 8'h00, 1, 4'h0, "shift_93_empty");

    // reset mid-stream drops pending nibbles
    step(0, 1, 1, 8'hAF, 1, 4'hA, "load_AF_before_reset");
    step(1, 1, 0, 8'h00, 1, 4'h0, "reset_midstream");
    step(0, 1, 0, 8'h00, 1, 4'h0, "shift_after_reset");

    // reset also clears while deselected
    step(0, 1, 1, 8'h71, 1, 4'h7, "load_71");
    step(1, 0, 0, 8'h00, 1, 4'h0, "reset_while_sel0");
    step(0, 0, 0, 8'h00, 0, 4'h0, "idle");

    guard = 0;
    while (q.size() > 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL scoreboard_drain: pending=%0d required=0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
